// File: rtl/fft_burst_ctrl.sv
// fft_burst_ctrl: run sequencer for the burst FFT/IFFT core and its stream source.
// For each frame of a run it sends one config word to the core, pulses the
// source start, waits for the input frame end and then the output frame end.
// Each output phase is guarded by a timeout, and frames are separated by an
// optional idle gap. The run repeats for the requested number of frames.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   run, abort              host start pulse (IDLE only) / synchronous abort
//   num_frames              frames per run (0 behaves as 1)
//   fwd_inv, scale_sch      core direction and scaling schedule, latched on run
//   cfg_valid/data/ready    core config channel; data = {8'h00, scale_sch, fwd_inv}
//   src_start               one-cycle start pulse to the source
//   in_* / out_*            monitored AXI-stream handshakes at core input/output
//   busy, done              not-idle flag / end-of-successful-run pulse
//   err_timeout             sticky timeout flag, cleared by the next accepted run
//   frames_done             frames completed in the current or last run
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for run
// S_CFG   | config word presented, waiting for cfg_ready
// S_START | src_start high for this single cycle
// S_IN    | waiting for the input frame last beat
// S_OUT   | waiting for the output frame last beat, timeout running
// S_GAP   | idle gap between frames
// S_DONE  | done pulse, back to idle
// S_ERR   | timeout seen, back to idle without done
module fft_burst_ctrl #(
  parameter int FRAME_CNT_W = 8,
  parameter int TIMEOUT_CYC = 4096,
  parameter int GAP_CYC     = 4,
  parameter int TO_W        = 13
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   abort,
  input  logic [FRAME_CNT_W-1:0] num_frames,
  input  logic                   fwd_inv,
  input  logic [14:0]            scale_sch,
  output logic                   cfg_valid,
  output logic [23:0]            cfg_data,
  input  logic                   cfg_ready,
  output logic                   src_start,
  input  logic                   in_valid,
  input  logic                   in_ready,
  input  logic                   in_last,
  input  logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err_timeout,
  output logic [FRAME_CNT_W-1:0] frames_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_START, S_IN, S_OUT, S_GAP, S_DONE, S_ERR
  } state_t;

  localparam logic [TO_W-1:0] TO_TC  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] GAP_TC = TO_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  state_t                 state;
  logic [FRAME_CNT_W-1:0] frames_req;
  logic [TO_W-1:0]        cnt;

  logic in_beat, out_beat, last_frame;

  assign in_beat    = in_valid & in_ready & in_last;
  assign out_beat   = out_valid & out_ready & out_last;
  // frames_req is never zero, so the subtraction cannot wrap
  assign last_frame = (frames_done >= (frames_req - FRAME_CNT_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cfg_valid   <= 1'b0;
      cfg_data    <= '0;
      src_start   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      frames_done <= '0;
      frames_req  <= FRAME_CNT_W'(1);
      cnt         <= '0;
    end else begin
      src_start <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        cfg_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (run) begin
              state       <= S_CFG;
              cfg_valid   <= 1'b1;
              // cfg_data doubles as the latched copy of fwd_inv/scale_sch
              cfg_data    <= {8'h00, scale_sch, fwd_inv};
              frames_req  <= (num_frames == '0) ? FRAME_CNT_W'(1) : num_frames;
              frames_done <= '0;
              err_timeout <= 1'b0;
              busy        <= 1'b1;
            end
          end
          S_CFG: begin
            if (cfg_ready) begin
              state     <= S_START;
              cfg_valid <= 1'b0;
              src_start <= 1'b1;
            end
          end
          S_START: state <= S_IN;
          S_IN: begin
            cnt <= '0;
            if (in_beat) state <= S_OUT;
          end
          S_OUT: begin
            // an out-beat on the terminal-count cycle still completes the frame
            if (out_beat) begin
              if (frames_done < frames_req) frames_done <= frames_done + FRAME_CNT_W'(1);
              if (last_frame) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else if (GAP_CYC == 0) begin
                state     <= S_CFG;
                cfg_valid <= 1'b1;
              end else begin
                state <= S_GAP;
                cnt   <= '0;
              end
            end else if (cnt == TO_TC) begin
              state       <= S_ERR;
              err_timeout <= 1'b1;
            end else begin
              cnt <= cnt + TO_W'(1);
            end
          end
          S_GAP: begin
            if (cnt == GAP_TC) begin
              state     <= S_CFG;
              cfg_valid <= 1'b1;
            end else begin
              cnt <= cnt + TO_W'(1);
            end
          end
          S_DONE, S_ERR: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state     <= S_IDLE;
            cfg_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_burst_ctrl.sv
module tb_fft_burst_ctrl;

  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0, abort = 1'b0;
  logic [FW-1:0] num_frames = '0;
  logic          fwd_inv = 1'b0;
  logic [14:0]   scale_sch = '0;
  logic          cfg_valid;
  logic [23:0]   cfg_data;
  logic          cfg_ready = 1'b1;
  logic          src_start;
  logic          in_valid = 1'b0, in_ready = 1'b0, in_last = 1'b0;
  logic          out_valid = 1'b0, out_ready = 1'b0, out_last = 1'b0;
  logic          busy, done, err_timeout;
  logic [FW-1:0] frames_done;

  int checks = 0;
  int errors = 0;

  int          n_cfg = 0, n_src = 0, n_done = 0, n_cfg_bad = 0;
  logic [23:0] exp_cfg = '0;

  fft_burst_ctrl #(.FRAME_CNT_W(FW), .TIMEOUT_CYC(4096), .GAP_CYC(4), .TO_W(13)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .abort(abort), .num_frames(num_frames),
    .fwd_inv(fwd_inv), .scale_sch(scale_sch), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .src_start(src_start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .err_timeout(err_timeout), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (cfg_valid && cfg_ready) begin
        n_cfg = n_cfg + 1;
        if (cfg_data !== exp_cfg) n_cfg_bad = n_cfg_bad + 1;
      end
      if (src_start) n_src = n_src + 1;
      if (done) n_done = n_done + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_src_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (src_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic in_beat_tick();
    in_valid = 1'b1; in_ready = 1'b1; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_ready = 1'b0; in_last = 1'b0;
  endtask

  task automatic out_beat_tick();
    out_valid = 1'b1; out_ready = 1'b1; out_last = 1'b1;
    tick();
    out_valid = 1'b0; out_ready = 1'b0; out_last = 1'b0;
  endtask

  // Ends at the sample point right after the out-beat edge
  task automatic do_frame(input int in_dly, input int out_dist, output bit ok);
    wait_src_start(ok);
    if (!ok) return;
    tick();
    repeat (in_dly) tick();
    in_beat_tick();
    repeat (out_dist - 1) tick();
    out_beat_tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({cfg_valid, cfg_data, src_start, busy, done, err_timeout, frames_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got cv=%b cd=%h ss=%b busy=%b done=%b err=%b fd=%0d, want all 0",
               cfg_valid, cfg_data, src_start, busy, done, err_timeout, frames_done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b cfg_valid=%b, want 0 0", busy, cfg_valid);
    end
  endtask

  task automatic test_multi_frame();
    int c0, s0, d0, b0;
    bit ok;
    num_frames = 8'd3; fwd_inv = 1'b1; scale_sch = 15'h2AB; cfg_ready = 1'b1;
    exp_cfg = {8'h00, 15'h2AB, 1'b1};
    c0 = n_cfg; s0 = n_src; d0 = n_done; b0 = n_cfg_bad;
    start_run();
    checks++;
    if (cfg_valid !== 1'b1 || cfg_data !== exp_cfg || busy !== 1'b1) begin
      errors++;
      $display("FAIL mf_first_cfg: cv=%b cd=%h busy=%b, want 1 %h 1", cfg_valid, cfg_data, busy, exp_cfg);
    end
    for (int f = 0; f < 3; f++) begin
      do_frame(2, 20, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL mf_src_start_timeout: frame %0d got no src_start, want pulse", f);
      end
    end
    checks++;
    if (done !== 1'b1 || frames_done !== 8'd3) begin
      errors++;
      $display("FAIL mf_done: done=%b frames_done=%0d, want 1 3", done, frames_done);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mf_idle_after: busy=%b done=%b, want 0 0", busy, done);
    end
    tick();
    checks++;
    if (n_cfg - c0 != 3 || n_src - s0 != 3 || n_done - d0 != 1 || n_cfg_bad - b0 != 0) begin
      errors++;
      $display("FAIL mf_counts: cfg=%0d src=%0d done=%0d badcfg=%0d, want 3 3 1 0",
               n_cfg - c0, n_src - s0, n_done - d0, n_cfg_bad - b0);
    end
  endtask

  task automatic test_cfg_stall();
    int bad = 0;
    num_frames = 8'd1; fwd_inv = 1'b0; scale_sch = 15'h1234; cfg_ready = 1'b0;
    exp_cfg = {8'h00, 15'h1234, 1'b0};
    start_run();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin fwd_inv = 1'b1; scale_sch = 15'h7FFF; end
      if (cfg_valid !== 1'b1 || cfg_data !== exp_cfg) bad++;
      if (i < 9) tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_stable: %0d unstable cycles, want 0 (cd=%h exp=%h)", bad, cfg_data, exp_cfg);
    end
    cfg_ready = 1'b1;
    tick();
    cfg_ready = 1'b0;
    checks++;
    if (src_start !== 1'b1 || cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_start: src_start=%b cfg_valid=%b, want 1 0", src_start, cfg_valid);
    end
    tick();
    checks++;
    if (src_start !== 1'b0) begin
      errors++;
      $display("FAIL stall_start_width: src_start=%b, want 0", src_start);
    end
    in_beat_tick();
    tick();
    out_beat_tick();
    checks++;
    if (done !== 1'b1 || frames_done !== 8'd1) begin
      errors++;
      $display("FAIL stall_done: done=%b frames_done=%0d, want 1 1", done, frames_done);
    end
    cfg_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int d0;
    bit ok;
    num_frames = 8'd1; fwd_inv = 1'b1; scale_sch = 15'h0001;
    exp_cfg = {8'h00, 15'h0001, 1'b1};
    d0 = n_done;
    start_run();
    wait_src_start(ok);
    tick();
    in_beat_tick();
    repeat (4095) tick();
    checks++;
    if (!ok || err_timeout !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_early: ok=%b err=%b busy=%b, want 1 0 1", ok, err_timeout, busy);
    end
    tick();
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_flag: err_timeout=%b, want 1", err_timeout);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || err_timeout !== 1'b1 || n_done != d0 || frames_done !== 8'd0) begin
      errors++;
      $display("FAIL to_idle: busy=%b err=%b dones=%0d fd=%0d, want 0 1 0 0",
               busy, err_timeout, n_done - d0, frames_done);
    end
    start_run();
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: err_timeout=%b, want 0", err_timeout);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_tc_outbeat();
    bit ok;
    num_frames = 8'd1;
    start_run();
    wait_src_start(ok);
    tick();
    in_beat_tick();
    repeat (4095) tick();
    out_beat_tick();
    checks++;
    if (!ok || err_timeout !== 1'b0 || done !== 1'b1 || frames_done !== 8'd1) begin
      errors++;
      $display("FAIL tc_outbeat: ok=%b err=%b done=%b fd=%0d, want 1 0 1 1",
               ok, err_timeout, done, frames_done);
    end
    tick(); tick();
  endtask

  task automatic test_abort();
    int d0;
    bit ok1, ok2;
    num_frames = 8'd4;
    d0 = n_done;
    start_run();
    do_frame(1, 6, ok1);
    wait_src_start(ok2);
    tick();
    in_beat_tick();
    repeat (3) tick();
    run = 1'b1;
    tick();
    run = 1'b0;
    checks++;
    if (!ok1 || !ok2 || busy !== 1'b1 || frames_done !== 8'd1) begin
      errors++;
      $display("FAIL ab_run_busy: ok=%b%b busy=%b fd=%0d, want 11 1 1", ok1, ok2, busy, frames_done);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || cfg_valid !== 1'b0 || src_start !== 1'b0 || done !== 1'b0 ||
        frames_done !== 8'd1 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL ab_state: busy=%b cv=%b ss=%b done=%b fd=%0d err=%b, want 0 0 0 0 1 0",
               busy, cfg_valid, src_start, done, frames_done, err_timeout);
    end
    repeat (10) tick();
    checks++;
    if (n_done != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ab_no_done: dones=%0d busy=%b, want 0 0", n_done - d0, busy);
    end
  endtask

  task automatic test_zero_frames();
    int s0;
    bit ok;
    num_frames = 8'd0;
    s0 = n_src;
    start_run();
    do_frame(0, 5, ok);
    checks++;
    if (!ok || done !== 1'b1 || frames_done !== 8'd1) begin
      errors++;
      $display("FAIL zero_done: ok=%b done=%b fd=%0d, want 1 1 1", ok, done, frames_done);
    end
    repeat (8) tick();
    checks++;
    if (n_src - s0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_single: src_starts=%0d busy=%b, want 1 0", n_src - s0, busy);
    end
  endtask

  task automatic test_reset_midcfg();
    num_frames = 8'd2; cfg_ready = 1'b0;
    start_run();
    checks++;
    if (cfg_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: cfg_valid=%b, want 1", cfg_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cfg_valid !== 1'b0 || busy !== 1'b0 || cfg_data !== 24'h0) begin
      errors++;
      $display("FAIL rst_async: cv=%b busy=%b cd=%h, want 0 0 000000", cfg_valid, busy, cfg_data);
    end
    tick();
    rst_n = 1'b1;
    cfg_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_multi_frame();
    test_cfg_stall();
    test_timeout();
    test_tc_outbeat();
    test_abort();
    test_zero_frames();
    test_reset_midcfg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
